pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register with stall/flush, scratch hold and perf counters
//
// Purpose:
//   Latches a payload word plus valid bit between two pipeline stages. It follows
//   the global stall vector (upstream bit STAGE, downstream bit STAGE+1) and the
//   exception flush. It also carries multi-cycle scratch state that is returned
//   to the upstream unit while that unit is stopped.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall[STALL_W]    global stall vector, 1 = stop
//   flush             kills the stage contents
//   in_data/in_valid  payload and valid from upstream
//   out_data/out_valid registered payload and valid to downstream
//   scr_i/scr_o       scratch state from/to the upstream multi-cycle unit
//   cnt_clr           zeroes the performance counters
//   bubble_cnt, hold_cnt, flush_cnt  saturating event counters
//   stall_err         sticky flag for the illegal pattern (upstream running, downstream stopped)
module pipe_stage_reg #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  NOP_VAL = '0,
    parameter int                 SCR_W   = 66,
    parameter int                 STALL_W = 6,
    parameter int                 STAGE   = 3,
    parameter int                 CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic [SCR_W-1:0]   scr_i,
    output logic [SCR_W-1:0]   scr_o,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic               stall_err
);

    generate
        if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
        end
    endgenerate

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [SCR_W-1:0]  scr_q, scr_d;
    logic [CNT_W-1:0]  bub_q, bub_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]  fl_q, fl_d;
    logic              err_q, err_d;

    logic su, sd;
    logic bub_inc, hold_inc, fl_inc;

    assign su = stall[STAGE];
    assign sd = stall[STAGE+1];

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        if (en && (c != {CNT_W{1'b1}})) begin
            return c + CNT_W'(1);
        end
        return c;
    endfunction

    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        scr_d    = scr_q;
        err_d    = err_q;
        bub_inc  = 1'b0;
        hold_inc = 1'b0;
        fl_inc   = 1'b0;

        if (flush) begin
            // Flush outranks the stall checks, so the error flag is not touched here.
            data_d  = NOP_VAL;
            valid_d = 1'b0;
            scr_d   = '0;
            fl_inc  = 1'b1;
        end else if (su && !sd) begin
            data_d  = NOP_VAL;
            valid_d = 1'b0;
            scr_d   = scr_i;
            bub_inc = 1'b1;
        end else if (!su) begin
            // Upstream is moving, so any new op must start from a clean scratch.
            data_d  = in_data;
            valid_d = in_valid;
            scr_d   = '0;
            if (sd) begin
                err_d = 1'b1;
            end
        end else begin
            scr_d    = scr_i;
            hold_inc = 1'b1;
        end

        if (cnt_clr) begin
            bub_d  = '0;
            hold_d = '0;
            fl_d   = '0;
        end else begin
            bub_d  = sat_inc(bub_q, bub_inc);
            hold_d = sat_inc(hold_q, hold_inc);
            fl_d   = sat_inc(fl_q, fl_inc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= NOP_VAL;
            valid_q <= 1'b0;
            scr_q   <= '0;
            bub_q   <= '0;
            hold_q  <= '0;
            fl_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            scr_q   <= scr_d;
            bub_q   <= bub_d;
            hold_q  <= hold_d;
            fl_q    <= fl_d;
            err_q   <= err_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign scr_o      = scr_q;
    assign bubble_cnt = bub_q;
    assign hold_cnt   = hold_q;
    assign flush_cnt  = fl_q;
    assign stall_err  = err_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP1 = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic [65:0] scr_i;
    logic        cnt_clr;

    logic [31:0] od0, od1;
    logic        ov0, ov1;
    logic [65:0] so0, so1;
    logic [15:0] bc0, hc0, fc0;
    logic [3:0]  bc1, hc1, fc1;
    logic        se0, se1;

    int total = 0;
    int bad   = 0;

    // Reference state: counts are kept unbounded; a saturating counter shows min(count, max).
    logic [31:0] m_data0, m_data1;
    logic        m_valid;
    logic [65:0] m_scr;
    logic        m_err;
    int          m_bc, m_hc, m_fc;

    always #5 clk = ~clk;

    pipe_stage_reg u0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(od0), .out_valid(ov0),
        .scr_i(scr_i), .scr_o(so0), .cnt_clr(cnt_clr),
        .bubble_cnt(bc0), .hold_cnt(hc0), .flush_cnt(fc0), .stall_err(se0)
    );

    pipe_stage_reg #(.NOP_VAL(NOP1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(od1), .out_valid(ov1),
        .scr_i(scr_i), .scr_o(so1), .cnt_clr(cnt_clr),
        .bubble_cnt(bc1), .hold_cnt(hc1), .flush_cnt(fc1), .stall_err(se1)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] din;
        logic        vin;
        logic [65:0] scr;
        logic [31:0] e_data;
        logic        e_valid;
        logic [65:0] e_scr;
        logic        e_err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_step();
        logic su, sd;
        su = stall[3];
        sd = stall[4];
        if (rst) begin
            m_data0 = 32'h0; m_data1 = NOP1; m_valid = 1'b0; m_scr = '0;
            m_err = 1'b0; m_bc = 0; m_hc = 0; m_fc = 0;
        end else begin
            if (flush) begin
                m_data0 = 32'h0; m_data1 = NOP1; m_valid = 1'b0; m_scr = '0;
                m_fc++;
            end else if (su && !sd) begin
                m_data0 = 32'h0; m_data1 = NOP1; m_valid = 1'b0; m_scr = scr_i;
                m_bc++;
            end else if (!su) begin
                m_data0 = in_data; m_data1 = in_data; m_valid = in_valid; m_scr = '0;
                if (sd) m_err = 1'b1;
            end else begin
                m_scr = scr_i;
                m_hc++;
            end
            if (cnt_clr) begin
                m_bc = 0; m_hc = 0; m_fc = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("u0_data",  od0, m_data0);
        chk("u1_data",  od1, m_data1);
        chk("u0_valid", ov0, m_valid);
        chk("u1_valid", ov1, m_valid);
        chk("u0_scr",   so0, m_scr);
        chk("u1_scr",   so1, m_scr);
        chk("u0_err",   se0, m_err);
        chk("u1_err",   se1, m_err);
        chk("u0_bub",   bc0, sat(m_bc, 65535));
        chk("u0_hold",  hc0, sat(m_hc, 65535));
        chk("u0_flush", fc0, sat(m_fc, 65535));
        chk("u1_bub",   bc1, sat(m_bc, 15));
        chk("u1_hold",  hc1, sat(m_hc, 15));
        chk("u1_flush", fc1, sat(m_fc, 15));
    endtask

    task automatic cycle(input logic r, input logic [5:0] st, input logic fl,
                         input logic [31:0] d, input logic v, input logic [65:0] s,
                         input logic clr);
        rst = r; stall = st; flush = fl; in_data = d; in_valid = v; scr_i = s; cnt_clr = clr;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; in_data = '0; in_valid = 1'b0;
        scr_i = '0; cnt_clr = 1'b0;

        //          rst stall      fl din           v scr              e_data       ev e_scr            err
        tbl[0]  = '{1, 6'b000000, 0, 32'hDEADBEEF, 1, 66'h0,           32'h0,       0, 66'h0,           0};
        tbl[1]  = '{1, 6'b000000, 0, 32'hDEADBEEF, 1, 66'h0,           32'h0,       0, 66'h0,           0};
        tbl[2]  = '{0, 6'b000000, 0, 32'h11,       1, 66'h0,           32'h11,      1, 66'h0,           0};
        tbl[3]  = '{0, 6'b000000, 0, 32'h22,       1, 66'h0,           32'h22,      1, 66'h0,           0};
        tbl[4]  = '{0, 6'b000000, 0, 32'h33,       1, 66'h0,           32'h33,      1, 66'h0,           0};
        tbl[5]  = '{0, 6'b001111, 0, 32'h99,       1, 66'h1_0000_0002, 32'h0,       0, 66'h1_0000_0002, 0};
        tbl[6]  = '{0, 6'b001111, 0, 32'h99,       1, 66'h1_0000_0002, 32'h0,       0, 66'h1_0000_0002, 0};
        tbl[7]  = '{0, 6'b001111, 0, 32'h99,       1, 66'h1_0000_0002, 32'h0,       0, 66'h1_0000_0002, 0};
        tbl[8]  = '{0, 6'b000000, 0, 32'h44,       1, 66'h0,           32'h44,      1, 66'h0,           0};
        tbl[9]  = '{0, 6'b011111, 0, 32'h66,       0, 66'h7,           32'h44,      1, 66'h7,           0};
        tbl[10] = '{0, 6'b011111, 0, 32'h66,       0, 66'h8,           32'h44,      1, 66'h8,           0};
        tbl[11] = '{0, 6'b011111, 1, 32'h66,       1, 66'h9,           32'h0,       0, 66'h0,           0};
        tbl[12] = '{0, 6'b010000, 0, 32'h55,       1, 66'h0,           32'h55,      1, 66'h0,           1};

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].din, tbl[i].vin, tbl[i].scr, 1'b0);
            chk($sformatf("tbl%0d_data", i),  od0, tbl[i].e_data);
            chk($sformatf("tbl%0d_valid", i), ov0, tbl[i].e_valid);
            chk($sformatf("tbl%0d_scr", i),   so0, tbl[i].e_scr);
            chk($sformatf("tbl%0d_err", i),   se0, tbl[i].e_err);
            if (i == 1) begin
                chk("rst_bub", bc0, 0);
                chk("rst_hold", hc0, 0);
                chk("rst_flush", fc0, 0);
            end
        end
        chk("bub_after_3", bc0, 3);
        chk("hold_after_2", hc0, 2);
        chk("flush_after_1", fc0, 1);

        // Sticky error survives legal traffic and only reset clears it.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, (i % 2 == 0) ? 6'b000000 : 6'b011000, 1'b0, 32'h100 + i, 1'b1, 66'h0, 1'b0);
        end
        chk("err_sticky", se0, 1'b1);
        cycle(1'b0, 6'b010000, 1'b1, 32'h77, 1'b1, 66'h3, 1'b0);
        chk("flush_beats_illegal_data", od1, NOP1);
        cycle(1'b1, 6'b111111, 1'b0, 32'h0, 1'b0, 66'h5, 1'b0);
        chk("err_cleared_by_rst", se0, 1'b0);

        // Illegal pattern masked by flush must not set the flag.
        cycle(1'b0, 6'b010000, 1'b1, 32'h78, 1'b1, 66'h0, 1'b0);
        chk("flush_masks_err", se1, 1'b0);

        // Saturation on the narrow instance, then clear alongside a bubble.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 6'b001000, 1'b0, 32'h0, 1'b1, 66'(i), 1'b0);
        end
        chk("u1_bub_sat", bc1, 4'd15);
        chk("u0_bub_20", bc0, 16'd20);
        cycle(1'b0, 6'b001000, 1'b0, 32'h0, 1'b1, 66'h0, 1'b1);
        chk("u1_bub_clr", bc1, 4'd0);
        chk("u0_bub_clr", bc0, 16'd0);

        // Reset mid hold clears the scratch regardless of stall.
        cycle(1'b0, 6'b011000, 1'b0, 32'h0, 1'b0, 66'h2_AAAA_0001, 1'b0);
        cycle(1'b1, 6'b011000, 1'b0, 32'h0, 1'b0, 66'h2_AAAA_0002, 1'b0);
        chk("rst_mid_op_scr", so0, 66'h0);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 59) == 0,
                  6'($urandom),
                  $urandom_range(0, 9) == 0,
                  $urandom,
                  1'($urandom),
                  {2'($urandom), $urandom, $urandom},
                  $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
